// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing the single-ported DRAM between the I-cache (refills)
// and the D-cache (refills and write-backs); one registered transaction at a time.
module riscv_mem_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int S_ADDR     = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [S_ADDR-1:0]     i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [S_ADDR-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [S_ADDR-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_e;

    state_e                state_q, state_d;
    logic                  last_d_q, last_d_d;   // 1 = D-cache won the previous grant
    logic                  we_q, we_d;
    logic [S_ADDR-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  i_ready_q, i_ready_d;
    logic                  d_ready_q, d_ready_d;
    logic                  grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        grant_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time goes first
                grant_d = d_req && (!i_req || !last_d_q);
                if (grant_d) begin
                    state_d  = BUSY_D;
                    last_d_d = 1'b1;
                    we_d     = d_we;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                end else if (i_req) begin
                    state_d  = BUSY_I;
                    last_d_d = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = i_addr;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    i_rdata_d = mem_rdata;
                    i_ready_d = 1'b1;
                    state_d   = RELEASE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    d_ready_d = 1'b1;
                    state_d   = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_rden = 1'b0;
        mem_wren = 1'b0;
        case (state_q)
            BUSY_I:  mem_rden = 1'b1;
            BUSY_D: begin
                mem_rden = !we_q;
                mem_wren = we_q;
            end
            default: ;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: vector table, directed corner sequences, and a
// randomized run checked against a transaction-level arbiter/DRAM model.
module tb_riscv_mem_arbiter;
    localparam int DW = 128;
    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we, mem_ready, i_ready, d_ready, mem_rden, mem_wren;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;

    riscv_mem_arbiter #(.DATA_WIDTH(DW), .S_ADDR(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic          ireq, dreq, dwe;
        logic [AW-1:0] iaddr, daddr;
        logic [DW-1:0] dwdata, rdata;
        int unsigned   lat;
        logic          exp_d;
        logic [DW-1:0] exp_x_rdata;
    } vec_t;

    vec_t tbl [8];

    task automatic run_vec(input vec_t v, input int idx);
        logic wr;
        wr = v.exp_d && v.dwe;
        i_req = v.ireq; d_req = v.dreq; d_we = v.dwe;
        i_addr = v.iaddr; d_addr = v.daddr; d_wdata = v.dwdata;
        tick();
        chk($sformatf("v%0d_grant_rden", idx), DW'(mem_rden), DW'(!wr));
        chk($sformatf("v%0d_grant_wren", idx), DW'(mem_wren), DW'(wr));
        chk($sformatf("v%0d_grant_addr", idx), DW'(mem_addr), DW'(v.exp_d ? v.daddr : v.iaddr));
        if (wr) chk($sformatf("v%0d_grant_wdata", idx), mem_wdata, v.dwdata);
        for (int unsigned c = 0; c < v.lat; c++) begin
            tick();
            chk($sformatf("v%0d_hold", idx), DW'({mem_rden, mem_wren, mem_addr}),
                DW'({!wr, wr, (v.exp_d ? v.daddr : v.iaddr)}));
        end
        mem_ready = 1'b1; mem_rdata = v.rdata;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        chk($sformatf("v%0d_rdy", idx), DW'({i_ready, d_ready}), DW'({!v.exp_d, v.exp_d}));
        chk($sformatf("v%0d_rdata", idx), v.exp_d ? d_rdata : i_rdata, v.exp_x_rdata);
        chk($sformatf("v%0d_strobe_low", idx), DW'({mem_rden, mem_wren}), '0);
        i_req = 1'b0; d_req = 1'b0;
        tick();
        chk($sformatf("v%0d_rdy_one_cycle", idx), DW'({i_ready, d_ready}), '0);
    endtask

    // ---------------- random-phase model state ----------------
    logic [DW-1:0] dram [logic [AW-1:0]];

    function automatic logic [DW-1:0] dram_read(input logic [AW-1:0] a);
        if (dram.exists(a)) return dram[a];
        return {4{9'h0, a}} ^ 128'hC0DE_0000_1234_5678_9ABC_DEF0_0F1E_2D3C;
    endfunction

    initial begin
        logic          got_d;
        logic          exp_order [4];
        int unsigned   grants, low_run, hold, pulses;
        logic          prev_strobe, strobe;
        logic [DW-1:0] x;
        // random model
        logic          m_free, busy, own_d, own_we, last_d, acc, acc_d, win_d;
        logic          ireq_s, dreq_s, rsp_s, i_drop, d_drop;
        logic [DW-1:0] rdat_s, own_wdata, m_ir, m_dr;
        logic [AW-1:0] own_addr;
        int unsigned   rel_cnt, lat_left, i_gap, d_gap, n_grants;
        logic [1:0]    exp_str;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 23'h00010, 23'h0, 128'h0,
                   128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF, 2, 1'b0,
                   128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 23'h0, 23'h7FFFFF, {DW{1'b1}},
                   128'h1111, 3, 1'b1, 128'h0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 23'h0, 23'h12345, 128'h0,
                   {16{8'hA5}}, 0, 1'b1, {16{8'hA5}}};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 23'h0, 23'h0, 128'h0123_4567_89AB_CDEF,
                   128'h2222, 1, 1'b1, {16{8'hA5}}};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 23'h7FFFFF, 23'h0, 128'h0,
                   128'h0, 4, 1'b0, 128'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 23'h200, 23'h100, 128'h0,
                   {16{8'hC3}}, 1, 1'b1, {16{8'hC3}}};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 23'h400, 23'h300, 128'h5,
                   {16{8'h77}}, 0, 1'b0, {16{8'h77}}};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 23'h600, 23'h500, 128'h0,
                   {16{8'h99}}, 2, 1'b1, {16{8'h99}}};

        // ---- reset values ----
        clear_inputs();
        rst = 1'b1;
        tick();
        chk("rst_strobes_ready", DW'({mem_rden, mem_wren, i_ready, d_ready}), '0);
        chk("rst_mem_addr", DW'(mem_addr), '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_i_rdata", i_rdata, '0);
        chk("rst_d_rdata", d_rdata, '0);
        rst = 1'b0;

        // ---- table ----
        for (int k = 0; k < 8; k++) run_vec(tbl[k], k);

        // ---- both requests held from reset: D, I, D, I ----
        do_reset();
        exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;
        i_req = 1'b1; d_req = 1'b1; i_addr = 23'h1; d_addr = 23'h2;
        grants = 0; low_run = 0; hold = 0; prev_strobe = 1'b0; got_d = 1'b0;
        for (int c = 0; c < 60 && grants < 4; c++) begin
            tick();
            strobe = mem_rden | mem_wren;
            if (strobe && !prev_strobe) begin
                got_d = (mem_addr == 23'h2);
                chk($sformatf("tie_order_%0d", grants), DW'(got_d), DW'(exp_order[grants]));
                if (grants > 0) chk($sformatf("tie_gap_%0d", grants), DW'(low_run), 2);
                grants++;
                low_run = 0;
                hold = 0;
            end
            if (!strobe && prev_strobe)
                chk("tie_ready_port", DW'({i_ready, d_ready}), DW'({!got_d, got_d}));
            if (strobe) begin
                hold++;
                mem_ready = (hold == 2);
            end else begin
                mem_ready = 1'b0;
                low_run++;
            end
            prev_strobe = strobe;
        end
        chk("tie_grant_count", DW'(grants), 4);

        // ---- d_req dropped during BUSY_D, then spurious mem_ready in IDLE ----
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 23'h5;
        tick();
        chk("drop_grant_rden", DW'({mem_rden, mem_wren}), DW'(2'b10));
        d_req = 1'b0;
        tick();
        tick();
        chk("drop_still_busy", DW'(mem_rden), 1);
        x = 128'hFEED_FACE_0000_1111_2222_3333_4444_5555;
        mem_ready = 1'b1; mem_rdata = x;
        tick();
        mem_ready = 1'b0;
        pulses = {31'd0, d_ready};
        chk("drop_d_rdata", d_rdata, x);
        for (int c = 0; c < 3; c++) begin
            tick();
            pulses += {31'd0, d_ready};
        end
        chk("drop_pulse_count", DW'(pulses), 1);
        mem_ready = 1'b1; mem_rdata = rnd128();
        tick();
        mem_ready = 1'b0;
        chk("spur_no_ready", DW'({i_ready, d_ready, mem_rden, mem_wren}), '0);
        chk("spur_rdata_kept", d_rdata, x);
        tick();
        chk("spur_still_idle", DW'({i_ready, d_ready, mem_rden, mem_wren}), '0);
        i_req = 1'b1; i_addr = 23'h9;
        tick();
        chk("spur_then_grant", DW'({mem_rden, mem_addr}), DW'({1'b1, 23'h9}));
        i_req = 1'b0;

        // ---- reset the cycle before mem_ready ----
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 23'h3; d_wdata = 128'hABCD;
        tick();
        chk("rstmid_grant_wren", DW'({mem_rden, mem_wren}), DW'(2'b01));
        tick();
        rst = 1'b1; d_req = 1'b0;
        tick();
        chk("rstmid_outputs", DW'({mem_rden, mem_wren, i_ready, d_ready, mem_addr}), '0);
        chk("rstmid_wdata", mem_wdata, '0);
        rst = 1'b0;
        mem_ready = 1'b1; mem_rdata = rnd128();
        tick();
        mem_ready = 1'b0;
        chk("rstmid_no_ready", DW'({i_ready, d_ready, mem_rden, mem_wren}), '0);
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 23'h11; d_addr = 23'h22;
        tick();
        chk("rstmid_tie_d_first", DW'({mem_rden, mem_addr}), DW'({1'b1, 23'h22}));
        i_req = 1'b0; d_req = 1'b0;

        // ---- randomized traffic vs transaction model ----
        do_reset();
        m_free = 1'b1; busy = 1'b0; own_d = 1'b0; own_we = 1'b0; last_d = 1'b0;
        own_addr = '0; own_wdata = '0; m_ir = '0; m_dr = '0;
        rel_cnt = 0; lat_left = 0; i_gap = 0; d_gap = 0; n_grants = 0;
        i_drop = 1'b0; d_drop = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ireq_s = i_req; dreq_s = d_req; rsp_s = mem_ready; rdat_s = mem_rdata;
            tick();
            if (rel_cnt > 0) begin
                rel_cnt--;
                if (rel_cnt == 0) m_free = 1'b1;
            end
            acc = 1'b0; acc_d = 1'b0;
            if (busy && rsp_s) begin
                acc = 1'b1; acc_d = own_d; busy = 1'b0; rel_cnt = 2;
            end else if (m_free && (ireq_s || dreq_s)) begin
                if (ireq_s && dreq_s) win_d = !last_d;
                else                  win_d = dreq_s;
                last_d = win_d; busy = 1'b1; m_free = 1'b0; own_d = win_d;
                own_we = win_d && d_we;
                own_addr = win_d ? d_addr : i_addr;
                own_wdata = d_wdata;
                lat_left = $urandom_range(0, 4);
                n_grants++;
            end
            chk("rand_ready", DW'({i_ready, d_ready}), DW'({acc && !acc_d, acc && acc_d}));
            if (acc) begin
                if (!acc_d) begin
                    m_ir = rdat_s;
                    chk("rand_i_rdata", i_rdata, m_ir);
                    i_req = 1'b0; i_gap = $urandom_range(0, 4); i_drop = 1'b1;
                end else begin
                    if (own_we) dram[own_addr] = own_wdata;
                    else        m_dr = rdat_s;
                    chk("rand_d_rdata", d_rdata, m_dr);
                    d_req = 1'b0; d_gap = $urandom_range(0, 4); d_drop = 1'b1;
                end
            end
            exp_str = busy ? (own_we ? 2'b01 : 2'b10) : 2'b00;
            chk("rand_strobes", DW'({mem_rden, mem_wren}), DW'(exp_str));
            if (busy) chk("rand_addr", DW'(mem_addr), DW'(own_addr));
            if (busy && own_we) chk("rand_wdata", mem_wdata, own_wdata);
            if (busy) begin
                if (lat_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = own_we ? rnd128() : dram_read(own_addr);
                end else begin
                    lat_left--;
                    mem_ready = 1'b0;
                end
            end else begin
                mem_ready = ($urandom_range(0, 7) == 0);
                mem_rdata = rnd128();
            end
            if (!i_req && !i_drop) begin
                if (i_gap == 0) begin
                    i_req = 1'b1; i_addr = AW'($urandom_range(0, 15));
                end else i_gap--;
            end
            if (!d_req && !d_drop) begin
                if (d_gap == 0) begin
                    d_req = 1'b1; d_addr = AW'($urandom_range(0, 15));
                    d_we = $urandom_range(0, 1) == 1; d_wdata = rnd128();
                end else d_gap--;
            end
            i_drop = 1'b0; d_drop = 1'b0;
        end
        chk("rand_enough_grants", DW'(n_grants > 200), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Two-port arbiter that shares the single-ported DRAM model between the instruction cache (read-only refills) and the data cache (refills and write-backs). It sits between the two cache controllers and the DRAM. It registers each granted request and holds the DRAM strobe until `mem_ready`, then returns read data to the winning requester. Ties are resolved round-robin so neither cache starves.

## Interface
Parameters:
- `DATA_WIDTH`, default 128, cache-block width in bits.
- `S_ADDR`, default 23, block-address width driven to DRAM.

Ports:
- `clk`, in, 1, single clock; all state updates on rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `i_req`, in, 1, I-cache read request; held high until `i_ready`.
- `i_addr`, in, S_ADDR, I-cache block address.
- `i_rdata`, out, DATA_WIDTH, I-cache read data; valid when `i_ready`=1.
- `i_ready`, out, 1, one-cycle completion pulse to I-cache.
- `d_req`, in, 1, D-cache request; held high until `d_ready`.
- `d_we`, in, 1, D-cache direction: 1 = write-back, 0 = refill.
- `d_addr`, in, S_ADDR, D-cache block address.
- `d_wdata`, in, DATA_WIDTH, D-cache write-back data.
- `d_rdata`, out, DATA_WIDTH, D-cache read data; valid when `d_ready`=1.
- `d_ready`, out, 1, one-cycle completion pulse to D-cache.
- `mem_rden`, out, 1, DRAM read strobe.
- `mem_wren`, out, 1, DRAM write strobe.
- `mem_addr`, out, S_ADDR, DRAM block address (registered).
- `mem_wdata`, out, DATA_WIDTH, DRAM write data (registered).
- `mem_rdata`, in, DATA_WIDTH, DRAM read data; valid in the `mem_ready` cycle.
- `mem_ready`, in, 1, DRAM completion pulse.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RELEASE.
- IDLE, request selection:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant the port opposite to `last_grant`.
- On grant:
  - Capture address (plus `d_wdata`/`d_we` for D) into `mem_addr`/`mem_wdata`.
  - Update `last_grant`.
  - Enter BUSY_I or BUSY_D.
- BUSY_x: hold `mem_rden` (or `mem_wren` when D with `d_we`=1) high and `mem_addr`/`mem_wdata` stable until `mem_ready`=1.
- `mem_ready` in BUSY_x:
  - Register `mem_rdata` into `i_rdata`/`d_rdata` (reads only; write returns hold the previous rdata value).
  - Drop the strobe.
  - Pulse the matching `x_ready` next cycle.
  - Go to RELEASE.
- RELEASE: one cycle with all strobes low, so the DRAM latency counter restarts; then IDLE.
- A requester whose `x_req` is still high when IDLE is re-entered is treated as a new request. Cache controllers drop `x_req` in the `x_ready` cycle.
- `x_req` deasserted during BUSY_x: ignored; the transaction completes and the `x_ready` pulse is still issued.
- `mem_ready` outside BUSY_x: ignored.
- `mem_rden` and `mem_wren` are never high together; at most one of `i_ready`/`d_ready` is high in any cycle.

## Timing
- Reset values:
  - State IDLE; `last_grant` = I, so the first tie goes to D.
  - All strobes, `i_ready` and `d_ready` at 0.
  - `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` at 0.
- Request sampled in IDLE at edge T: strobe and address visible from T+1.
- `mem_ready` sampled at edge K:
  - Strobe low and `x_ready`=1 with data valid during cycle K+1 (RELEASE).
  - IDLE at K+2.
  - Next strobe at the earliest from K+3.
- Overhead per transaction: 3 cycles beyond DRAM latency.
- `rst` asserted mid-transaction:
  - All outputs reach reset values at the next edge.
  - No `x_ready` issued; the transaction is abandoned.

## Test plan
- Reset, then `i_req`=1, `i_addr`=0x00010 → `mem_rden`=1 one cycle later with `mem_addr`=0x00010. DRAM returns 0xDEAD…BEEF on `mem_ready` → `i_ready`=1 for exactly one cycle with `i_rdata`=0xDEAD…BEEF; `mem_rden` low that cycle.
- `d_req`=1, `d_we`=1, `d_addr`=0x7FFFFF, `d_wdata`=all-ones → `mem_wren`=1, `mem_rden`=0, data held stable until `mem_ready`; `d_ready` pulse follows, and `d_rdata` keeps its previous value.
- `i_req` and `d_req` both high from reset and held → grant order D, I, D, I. Each grant is separated by a RELEASE cycle with both strobes low.
- `d_req` dropped during BUSY_D → transaction completes and `d_ready` still pulses once. A spurious `mem_ready` in IDLE → no ready pulse and no state change.
- `rst` asserted the cycle before `mem_ready` → no `i_ready`/`d_ready`, strobes 0 at the next edge, and the next tie grants D first.
